systolic_tile_sequencer: RTL and testbench
==========================================

// Module: systolic_tile_sequencer
// PURPOSE
//  Sequences one weight-stationary tile operation on the NxN systolic array: weight load, skewed activation
//  streaming, result write-back. Sits between the host start/done handshake and the array's load_weight /
//  enable_mult row controls, plus the weight, activation and result buffer ports. One tile per start.
// PARAMETERS
//  MATRIX_SIZE  2   array dimension N; rows/cols of PEs; legal >= 2
//  DATA_SIZE    32  PE operand width; carried for package consistency, no datapath here
//  STEP_CYCLES  4   cycles per systolic step (PE multiply-accumulate latency); legal >= 1
// PORTS
//  clk            in   1               clock, rising edge
//  reset          in   1               asynchronous, active-high
//  general_enable in   1               1 = advance; 0 = freeze all state for the cycle
//  start          in   1               request a tile; sampled only in IDLE
//  busy           out  1               high in LOAD_W and STREAM
//  done           out  1               one-cycle pulse in DONE
//  w_rd_en        out  1               weight buffer read strobe
//  w_rd_addr      out  $clog2(N)       weight row address
//  load_weight    out  N               one-hot row capture strobe; bit r = array row r
//  a_rd_en        out  1               activation buffer read strobe
//  a_rd_addr      out  $clog2(N)       activation row address
//  enable_mult    out  N               per-row PE enable; bit r = array row r
//  res_wr_en      out  1               result buffer write strobe
//  res_wr_addr    out  $clog2(N)       result row address
// BEHAVIOUR
//  - All outputs registered. Reset (any time, incl. mid-tile): state IDLE, counters 0, every output 0, no done.
//  - FSM: IDLE -> LOAD_W -> STREAM -> DONE -> IDLE. start=1 in IDLE with general_enable=1 (cycle 0) ->
//    LOAD_W from cycle 1. start in any other state ignored, never queued.
//  - LOAD_W lasts N+1 cycles, k = 0..N: w_rd_en=1, w_rd_addr=k for k<N; buffer read latency is 1 cycle,
//    so load_weight = 1<<(k-1) for k>=1. At most one load_weight bit set per cycle.
//  - STREAM lasts (2N-1)*STEP_CYCLES cycles; step s = 0..2N-2, phase p = 0..STEP_CYCLES-1.
//    a_rd_en=1, a_rd_addr=s at p=0 when s<N.  enable_mult[r]=1 when r <= s <= r+N-1 (diagonal skew).
//    res_wr_en=1, res_wr_addr=s-(N-1) at p=STEP_CYCLES-1 when s >= N-1.
//  - DONE: one cycle, done=1, busy=0, all strobes 0 and enable_mult=0; next state IDLE. A start
//    coincident with DONE is dropped; earliest accepted restart is the following IDLE cycle.
//  - done appears in cycle N+2+(2N-1)*STEP_CYCLES after the start cycle (N=2,STEP=4 -> cycle 16).
//  - general_enable=0: FSM, step and phase counters hold. w_rd_en, a_rd_en, res_wr_en, load_weight,
//    enable_mult and done forced to 0 that cycle; busy holds. Resume continues from the frozen point with
//    no skipped or duplicated strobes. A freeze on the DONE cycle delays the pulse, never drops it.
//  - Counters saturate at their terminal values, never wrap; addresses never exceed N-1.
// STRUCTURE
//  - Package systolic_pkg: state enum (IDLE, LOAD_W, STREAM, DONE), ADDR_W=$clog2(N),
//    STEP_W=$clog2(2N-1), PHASE_W=$clog2(STEP_CYCLES) (minimum 1).
//  - Sub-module systolic_step_counter: phase/step counter with enable, clear and terminal flags
//    last_phase and last_step. The FSM and output decode live in this module.
// TESTING
//  - N=2,STEP=4, general_enable=1, start pulse at cycle 0 -> busy cycles 1..15; load_weight 01@2, 10@3;
//    a_rd_en@4(addr0),8(addr1); res_wr_en@11(addr0),15(addr1); done@16 only.
//  - Same config: check enable_mult = 01 steps 0, 11 step 1, 10 step 2, 00 in DONE.
//  - start held high continuously -> back-to-back tiles; second LOAD_W begins cycle 18 (first IDLE is 17).
//  - reset asserted at cycle 7 mid-STREAM -> all outputs 0 same cycle; no done; new start works normally.
//  - general_enable low cycles 5..7 -> strobes 0 there; full timeline shifted by 3, done@19.
//  - N=4,STEP=1 -> 4 loads, 7 stream cycles, res_wr_addr 0..3 on cycles 9..12, done@13.

Source files
------------

// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared state encoding and width helpers for the tile sequencer
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int DEF_MATRIX_SIZE = 2;
  localparam int DEF_DATA_SIZE   = 32;
  localparam int DEF_STEP_CYCLES = 4;

  // Row address width for an N-row array.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Step counter width: steps run 0..2N-2; also wide enough to hold the load index 0..N.
  function automatic int step_w(input int n);
    return (n > 1) ? $clog2(2 * n - 1) : 1;
  endfunction

  // Phase counter width, never narrower than one bit.
  function automatic int phase_w(input int step_cycles);
    return (step_cycles > 1) ? $clog2(step_cycles) : 1;
  endfunction

endpackage

// File: rtl/systolic_step_counter.sv
// rtl/systolic_step_counter.sv - saturating phase/step counter for the streaming window
module systolic_step_counter
  import systolic_pkg::*;
#(
  parameter int STEP_W     = 2,
  parameter int PHASE_W    = 2,
  parameter int LAST_STEP  = 2,
  parameter int LAST_PHASE = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en_i,
  input  logic               clr_i,
  output logic [STEP_W-1:0]  step_nxt_o,
  output logic [PHASE_W-1:0] phase_nxt_o,
  output logic               last_step_o,
  output logic               last_phase_o
);

  localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(LAST_STEP);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(LAST_PHASE);

  logic [STEP_W-1:0]  step_q, step_d;
  logic [PHASE_W-1:0] phase_q, phase_d;

  assign last_step_o  = (step_q == STEP_LAST);
  assign last_phase_o = (phase_q == PHASE_LAST);
  assign step_nxt_o   = step_d;
  assign phase_nxt_o  = phase_d;

  // Next count: clear wins, then advance phase and roll into step; hold once both are terminal.
  always_comb begin
    step_d  = step_q;
    phase_d = phase_q;
    if (clr_i) begin
      step_d  = '0;
      phase_d = '0;
    end else if (en_i && !(last_step_o && last_phase_o)) begin
      if (last_phase_o) begin
        phase_d = '0;
        step_d  = step_q + 1'b1;
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q  <= '0;
      phase_q <= '0;
    end else begin
      step_q  <= step_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/systolic_tile_sequencer.sv
// rtl/systolic_tile_sequencer.sv - weight load, skewed streaming and write-back sequencing for one tile
module systolic_tile_sequencer
  import systolic_pkg::*;
#(
  parameter int MATRIX_SIZE = DEF_MATRIX_SIZE,
  parameter int DATA_SIZE   = DEF_DATA_SIZE,
  parameter int STEP_CYCLES = DEF_STEP_CYCLES,
  localparam int ADDR_W     = addr_w(MATRIX_SIZE)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   general_enable,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   w_rd_en,
  output logic [ADDR_W-1:0]      w_rd_addr,
  output logic [MATRIX_SIZE-1:0] load_weight,
  output logic                   a_rd_en,
  output logic [ADDR_W-1:0]      a_rd_addr,
  output logic [MATRIX_SIZE-1:0] enable_mult,
  output logic                   res_wr_en,
  output logic [ADDR_W-1:0]      res_wr_addr
);

  localparam int STEP_W  = step_w(MATRIX_SIZE);
  localparam int PHASE_W = phase_w(STEP_CYCLES);
  localparam logic [STEP_W-1:0]  N_S    = STEP_W'(MATRIX_SIZE);
  localparam logic [STEP_W-1:0]  NM1_S  = STEP_W'(MATRIX_SIZE - 1);
  localparam logic [PHASE_W-1:0] P_LAST = PHASE_W'(STEP_CYCLES - 1);

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   k_q, k_d;
  logic                cnt_en, cnt_clr;
  logic [STEP_W-1:0]   step_nxt, res_diff;
  logic [PHASE_W-1:0]  phase_nxt;
  logic                last_step, last_phase;

  logic                   busy_q, busy_d, done_q, done_d;
  logic                   w_rd_en_q, w_rd_en_d, a_rd_en_q, a_rd_en_d, res_wr_en_q, res_wr_en_d;
  logic [ADDR_W-1:0]      w_rd_addr_q, w_rd_addr_d, a_rd_addr_q, a_rd_addr_d;
  logic [ADDR_W-1:0]      res_wr_addr_q, res_wr_addr_d;
  logic [MATRIX_SIZE-1:0] load_weight_q, load_weight_d, enable_mult_q, enable_mult_d;

  systolic_step_counter #(
    .STEP_W    (STEP_W),
    .PHASE_W   (PHASE_W),
    .LAST_STEP (2 * MATRIX_SIZE - 2),
    .LAST_PHASE(STEP_CYCLES - 1)
  ) u_step_counter (
    .clk         (clk),
    .reset       (reset),
    .en_i        (cnt_en),
    .clr_i       (cnt_clr),
    .step_nxt_o  (step_nxt),
    .phase_nxt_o (phase_nxt),
    .last_step_o (last_step),
    .last_phase_o(last_phase)
  );

  // Next state: everything holds while general_enable is low.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
    if (general_enable) begin
      case (state_q)
        IDLE: if (start) begin
          state_d = LOAD_W;
          k_d     = '0;
        end
        LOAD_W: if (k_q == N_S) begin
          state_d = STREAM;
          cnt_clr = 1'b1;
        end else begin
          k_d = k_q + 1'b1;
        end
        STREAM: if (last_step && last_phase) state_d = DONE;
                else cnt_en = 1'b1;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output decode from the position the sequencer moves to, so the strobes land registered.
  always_comb begin
    busy_d        = (state_d == LOAD_W) || (state_d == STREAM);
    done_d        = 1'b0;
    w_rd_en_d     = 1'b0;
    w_rd_addr_d   = '0;
    load_weight_d = '0;
    a_rd_en_d     = 1'b0;
    a_rd_addr_d   = '0;
    enable_mult_d = '0;
    res_wr_en_d   = 1'b0;
    res_wr_addr_d = '0;
    res_diff      = step_nxt - NM1_S;
    case (state_d)
      LOAD_W: begin
        if (k_d < N_S) begin
          w_rd_en_d   = 1'b1;
          w_rd_addr_d = k_d[ADDR_W-1:0];
        end
        // Buffer read data arrives one cycle later, so row k-1 captures at index k.
        for (int r = 0; r < MATRIX_SIZE; r++) load_weight_d[r] = (k_d == STEP_W'(r + 1));
      end
      STREAM: begin
        if (phase_nxt == '0 && step_nxt < N_S) begin
          a_rd_en_d   = 1'b1;
          a_rd_addr_d = step_nxt[ADDR_W-1:0];
        end
        for (int r = 0; r < MATRIX_SIZE; r++)
          enable_mult_d[r] = (step_nxt >= STEP_W'(r)) && (step_nxt <= STEP_W'(r + MATRIX_SIZE - 1));
        if (phase_nxt == P_LAST && step_nxt >= NM1_S) begin
          res_wr_en_d   = 1'b1;
          res_wr_addr_d = res_diff[ADDR_W-1:0];
        end
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  // State, load index and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      k_q           <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      w_rd_en_q     <= 1'b0;
      w_rd_addr_q   <= '0;
      load_weight_q <= '0;
      a_rd_en_q     <= 1'b0;
      a_rd_addr_q   <= '0;
      enable_mult_q <= '0;
      res_wr_en_q   <= 1'b0;
      res_wr_addr_q <= '0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      w_rd_en_q     <= w_rd_en_d;
      w_rd_addr_q   <= w_rd_addr_d;
      load_weight_q <= load_weight_d;
      a_rd_en_q     <= a_rd_en_d;
      a_rd_addr_q   <= a_rd_addr_d;
      enable_mult_q <= enable_mult_d;
      res_wr_en_q   <= res_wr_en_d;
      res_wr_addr_q <= res_wr_addr_d;
    end
  end

  // A frozen cycle masks every strobe immediately; the registers keep the frozen position for resume.
  assign busy        = busy_q;
  assign done        = done_q & general_enable;
  assign w_rd_en     = w_rd_en_q & general_enable;
  assign w_rd_addr   = w_rd_addr_q;
  assign load_weight = load_weight_q & {MATRIX_SIZE{general_enable}};
  assign a_rd_en     = a_rd_en_q & general_enable;
  assign a_rd_addr   = a_rd_addr_q;
  assign enable_mult = enable_mult_q & {MATRIX_SIZE{general_enable}};
  assign res_wr_en   = res_wr_en_q & general_enable;
  assign res_wr_addr = res_wr_addr_q;

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// tb/tb_systolic_tile_sequencer.sv - directed bench for the tile sequencer (N=2/STEP=4 and N=4/STEP=1)
module tb_systolic_tile_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, general_enable = 1'b1;
  logic start4 = 1'b0, general_enable4 = 1'b1;

  logic       busy, done, w_rd_en, a_rd_en, res_wr_en;
  logic [0:0] w_rd_addr, a_rd_addr, res_wr_addr;
  logic [1:0] load_weight, enable_mult;

  logic       busy4, done4, w_rd_en4, a_rd_en4, res_wr_en4;
  logic [1:0] w_rd_addr4, a_rd_addr4, res_wr_addr4;
  logic [3:0] load_weight4, enable_mult4;

  int checks = 0;
  int failures = 0;

  localparam logic [11:0] FREEZE_KEEP = 12'h911;

  always #5 clk = ~clk;

  systolic_tile_sequencer #(.MATRIX_SIZE(2), .DATA_SIZE(32), .STEP_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .general_enable(general_enable), .start(start),
    .busy(busy), .done(done), .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr),
    .load_weight(load_weight), .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr),
    .enable_mult(enable_mult), .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr)
  );

  systolic_tile_sequencer #(.MATRIX_SIZE(4), .DATA_SIZE(32), .STEP_CYCLES(1)) dut4 (
    .clk(clk), .reset(reset), .general_enable(general_enable4), .start(start4),
    .busy(busy4), .done(done4), .w_rd_en(w_rd_en4), .w_rd_addr(w_rd_addr4),
    .load_weight(load_weight4), .a_rd_en(a_rd_en4), .a_rd_addr(a_rd_addr4),
    .enable_mult(enable_mult4), .res_wr_en(res_wr_en4), .res_wr_addr(res_wr_addr4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  // {busy, done, w_rd_en, w_rd_addr, load_weight, a_rd_en, a_rd_addr, enable_mult, res_wr_en, res_wr_addr}
  function automatic logic [11:0] pack2();
    return {busy, done, w_rd_en, w_rd_addr, load_weight, a_rd_en, a_rd_addr,
            enable_mult, res_wr_en, res_wr_addr};
  endfunction

  function automatic logic [18:0] pack4();
    return {busy4, done4, w_rd_en4, w_rd_addr4, load_weight4, a_rd_en4, a_rd_addr4,
            enable_mult4, res_wr_en4, res_wr_addr4};
  endfunction

  // Nominal N=2, STEP=4 timeline, cycle c counted from the start cycle.
  function automatic logic [11:0] exp_n2(input int c);
    logic [11:0] e;
    e = '0;
    e[11]  = (c >= 1 && c <= 15);
    e[10]  = (c == 16);
    e[9]   = (c == 1 || c == 2);
    e[8]   = (c == 2);
    e[7:6] = (c == 2) ? 2'b01 : (c == 3) ? 2'b10 : 2'b00;
    e[5]   = (c == 4 || c == 8);
    e[4]   = (c == 8);
    e[3:2] = (c >= 4 && c <= 7) ? 2'b01 : (c >= 8 && c <= 11) ? 2'b11 :
             (c >= 12 && c <= 15) ? 2'b10 : 2'b00;
    e[1]   = (c == 11 || c == 15);
    e[0]   = (c == 15);
    return e;
  endfunction

  // Addresses are only meaningful while their strobe is expected.
  function automatic logic [11:0] care2(input logic [11:0] e);
    logic [11:0] m;
    m = '1;
    if (!e[9]) m[8] = 1'b0;
    if (!e[5]) m[4] = 1'b0;
    if (!e[1]) m[0] = 1'b0;
    return m;
  endfunction

  // mode 0: single tile with optional freeze window [lo,hi]; 1: start held high; 2: idle, no start.
  function automatic logic [11:0] model2(input int c, input int lo, input int hi, input int mode);
    if (mode == 1) return exp_n2(c % 17);
    if (mode == 2) return 12'h000;
    if (c < lo) return exp_n2(c);
    if (c <= hi) return exp_n2(lo) & FREEZE_KEEP;
    return exp_n2(c - (hi - lo + 1));
  endfunction

  function automatic logic [18:0] exp_n4(input int c);
    logic [18:0] e;
    e = '0;
    e[18] = (c >= 1 && c <= 12);
    e[17] = (c == 13);
    if (c >= 1 && c <= 4) begin e[16] = 1'b1; e[15:14] = 2'(c - 1); end
    if (c >= 2 && c <= 5) e[13:10] = 4'(1 << (c - 2));
    if (c >= 6 && c <= 9) begin e[9] = 1'b1; e[8:7] = 2'(c - 6); end
    case (c)
      6:  e[6:3] = 4'b0001;
      7:  e[6:3] = 4'b0011;
      8:  e[6:3] = 4'b0111;
      9:  e[6:3] = 4'b1111;
      10: e[6:3] = 4'b1110;
      11: e[6:3] = 4'b1100;
      12: e[6:3] = 4'b1000;
      default: e[6:3] = 4'b0000;
    endcase
    if (c >= 9 && c <= 12) begin e[2] = 1'b1; e[1:0] = 2'(c - 9); end
    return e;
  endfunction

  function automatic logic [18:0] care4(input logic [18:0] e);
    logic [18:0] m;
    m = '1;
    if (!e[16]) m[15:14] = 2'b00;
    if (!e[9])  m[8:7]   = 2'b00;
    if (!e[2])  m[1:0]   = 2'b00;
    return m;
  endfunction

  // Called and returns one time unit after a rising edge.
  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    start4 = 1'b0;
    general_enable = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic run_n2(input string name, input int ncyc, input int lo, input int hi, input int mode);
    logic [11:0] e, m;
    for (int c = 0; c < ncyc; c++) begin
      start = (mode == 1) || (mode == 0 && c == 0);
      general_enable = !(c >= lo && c <= hi);
      @(negedge clk);
      e = model2(c, lo, hi, mode);
      m = care2(e);
      check_eq($sformatf("%s c%0d", name, c), 32'(pack2() & m), 32'(e & m));
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    general_enable = 1'b1;
  endtask

  initial begin
    logic [18:0] e4, m4;

    do_reset();
    @(negedge clk);
    check_eq("reset_n2", 32'(pack2()), 32'h0);
    check_eq("reset_n4", 32'(pack4()), 32'h0);
    @(posedge clk);
    #1;

    run_n2("nominal", 19, 1000, 999, 0);

    do_reset();
    run_n2("b2b", 35, 1000, 999, 1);

    do_reset();
    run_n2("rst_pre", 7, 1000, 999, 0);
    reset = 1'b1;
    #1;
    check_eq("rst_async", 32'(pack2()), 32'h0);
    @(negedge clk);
    check_eq("rst_hold", 32'(pack2()), 32'h0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 reset = 1'b0;
    run_n2("rst_idle", 12, 1000, 999, 2);
    run_n2("rst_restart", 18, 1000, 999, 0);

    do_reset();
    run_n2("freeze_stream", 22, 5, 7, 0);

    do_reset();
    run_n2("freeze_done", 21, 16, 17, 0);

    do_reset();
    run_n2("freeze_load", 20, 2, 2, 0);

    do_reset();
    for (int c = 0; c < 15; c++) begin
      start4 = (c == 0);
      @(negedge clk);
      e4 = exp_n4(c);
      m4 = care4(e4);
      check_eq($sformatf("n4 c%0d", c), 32'(pack4() & m4), 32'(e4 & m4));
      @(posedge clk);
      #1;
    end
    start4 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
